// File: rtl/entropy_src_repcnt_ctrl_if.sv
// Link between the repetitive-count test controller and the repcnt test instance:
// sample/fail/count/error flow from the test; active/clear flow back to it.
interface entropy_src_repcnt_ctrl_if #(
    parameter int RegWidth = 16
);
    logic                entropy_bit_vld_i;
    logic                test_fail_pulse_i;
    logic [RegWidth-1:0] test_cnt_i;
    logic                count_err_i;
    logic                ht_active_o;
    logic                ht_clear_o;

    modport master (
        input  entropy_bit_vld_i, test_fail_pulse_i, test_cnt_i, count_err_i,
        output ht_active_o, ht_clear_o
    );

    modport slave (
        output entropy_bit_vld_i, test_fail_pulse_i, test_cnt_i, count_err_i,
        input  ht_active_o, ht_clear_o
    );
endinterface

// File: rtl/entropy_src_repcnt_ctrl.sv
// Sequences the repcnt health test: windowing of the sample stream, startup
// qualification, continuous monitoring and a sticky alert on repeated failing windows.
module entropy_src_repcnt_ctrl #(
    parameter int RegWidth     = 16,
    parameter int WinWidth     = 16,
    parameter int FailCntWidth = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    entropy_src_repcnt_ctrl_if.master ht_if,
    input  logic                    enable_i,
    input  logic [WinWidth-1:0]     window_i,
    input  logic [3:0]              startup_wins_i,
    input  logic [FailCntWidth-1:0] alert_thresh_i,
    output logic                    window_done_o,
    output logic                    window_fail_o,
    output logic                    startup_done_o,
    output logic [RegWidth-1:0]     watermark_o,
    output logic [RegWidth-1:0]     fail_total_o,
    output logic                    alert_o,
    output logic                    err_o
);

    typedef enum logic [3:0] {
        IDLE    = 4'b0001,
        STARTUP = 4'b0010,
        CONT    = 4'b0100,
        ALERT   = 4'b1000
    } state_e;

    state_e                  state_q, state_d;
    logic                    clear_q, clear_d;
    logic                    illegal_state;
    logic                    active, counting, win_close;
    logic [WinWidth-1:0]     win_cnt_q, win_last;
    logic                    close_pend_q, fail_flag_q;
    logic [3:0]              pass_cnt_q;
    logic [4:0]              pass_inc;
    logic [FailCntWidth-1:0] fail_cnt_q, fail_cnt_inc;
    logic                    thresh_hit;
    logic [RegWidth-1:0]     watermark_q, fail_total_q;
    logic                    alert_q, err_q;

    assign active    = (state_q == STARTUP) || (state_q == CONT) || (state_q == ALERT);
    assign counting  = active && enable_i && !clear_q;
    assign win_last  = (window_i == '0) ? '0 : window_i - WinWidth'(1);
    assign win_close = counting && ht_if.entropy_bit_vld_i && (win_cnt_q == win_last);

    // The result is reported the cycle after the last strobe so that sample's fail pulse is included.
    assign window_done_o = close_pend_q && enable_i;
    assign window_fail_o = window_done_o && (fail_flag_q || ht_if.test_fail_pulse_i);

    assign pass_inc     = {1'b0, pass_cnt_q} + 5'd1;
    assign fail_cnt_inc = (fail_cnt_q == '1) ? fail_cnt_q : fail_cnt_q + FailCntWidth'(1);
    assign thresh_hit   = (alert_thresh_i != '0) && (fail_cnt_inc >= alert_thresh_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            clear_q <= 1'b0;
        end else begin
            state_q <= state_d;
            clear_q <= clear_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        clear_d       = 1'b0;
        illegal_state = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable_i) begin
                    state_d = STARTUP;
                    clear_d = 1'b1;
                end
            end
            STARTUP: begin
                if (clear_q) begin
                    if (startup_wins_i == '0) state_d = CONT;
                end else if (window_done_o) begin
                    if (window_fail_o) begin
                        if (thresh_hit) state_d = ALERT;
                    end else if (pass_inc >= {1'b0, startup_wins_i}) begin
                        state_d = CONT;
                    end
                end
            end
            CONT: begin
                if (window_fail_o && thresh_hit) state_d = ALERT;
            end
            ALERT: begin
                state_d = ALERT;
            end
            default: begin
                illegal_state = 1'b1;
                state_d       = ALERT;
            end
        endcase
        // An illegal encoding must land in ALERT even if the block is being disabled.
        if (!enable_i && !illegal_state) begin
            state_d = IDLE;
            clear_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            win_cnt_q    <= '0;
            close_pend_q <= 1'b0;
            fail_flag_q  <= 1'b0;
            pass_cnt_q   <= '0;
            fail_cnt_q   <= '0;
            watermark_q  <= '0;
            fail_total_q <= '0;
            alert_q      <= 1'b0;
        end else if (clear_q) begin
            win_cnt_q    <= '0;
            close_pend_q <= 1'b0;
            fail_flag_q  <= 1'b0;
            pass_cnt_q   <= '0;
            fail_cnt_q   <= '0;
            watermark_q  <= '0;
            fail_total_q <= '0;
            alert_q      <= 1'b0;
        end else begin
            close_pend_q <= win_close;
            if (win_close) begin
                win_cnt_q <= '0;
            end else if (counting && ht_if.entropy_bit_vld_i) begin
                win_cnt_q <= win_cnt_q + WinWidth'(1);
            end

            // A pulse in the report cycle belongs to the closing window, so the new window starts clean.
            if (window_done_o) begin
                fail_flag_q <= 1'b0;
            end else if (counting && ht_if.test_fail_pulse_i) begin
                fail_flag_q <= 1'b1;
            end

            if (window_done_o && (state_q == STARTUP || state_q == CONT)) begin
                if (window_fail_o) begin
                    fail_cnt_q <= fail_cnt_inc;
                    if (fail_total_q != '1) fail_total_q <= fail_total_q + RegWidth'(1);
                    if (state_q == STARTUP) pass_cnt_q <= '0;
                end else if (state_q == STARTUP) begin
                    pass_cnt_q <= pass_inc[3:0];
                end else begin
                    fail_cnt_q <= '0;
                end
            end

            if (active && (ht_if.test_cnt_i > watermark_q)) watermark_q <= ht_if.test_cnt_i;
            if (state_d == ALERT) alert_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if (ht_if.count_err_i || illegal_state) begin
            err_q <= 1'b1;
        end
    end

    assign ht_if.ht_active_o = active;
    assign ht_if.ht_clear_o  = clear_q;
    assign startup_done_o    = (state_q == CONT) || (state_q == ALERT);
    assign watermark_o       = watermark_q;
    assign fail_total_o      = fail_total_q;
    assign alert_o           = alert_q;
    assign err_o             = err_q;

endmodule

// File: tb/tb_entropy_src_repcnt_ctrl.sv
// Directed bench for entropy_src_repcnt_ctrl: a phase-level reference model checked
// every cycle, plus literal expectations at the scenario milestones.
module tb_entropy_src_repcnt_ctrl;

    localparam int RegWidth     = 16;
    localparam int WinWidth     = 16;
    localparam int FailCntWidth = 4;

    logic                    clk_i = 1'b0;
    logic                    rst_ni;
    logic                    enable_i;
    logic [WinWidth-1:0]     window_i;
    logic [3:0]              startup_wins_i;
    logic [FailCntWidth-1:0] alert_thresh_i;
    logic                    window_done_o, window_fail_o, startup_done_o;
    logic [RegWidth-1:0]     watermark_o, fail_total_o;
    logic                    alert_o, err_o;

    entropy_src_repcnt_ctrl_if #(.RegWidth(RegWidth)) ht_if ();

    entropy_src_repcnt_ctrl #(
        .RegWidth(RegWidth), .WinWidth(WinWidth), .FailCntWidth(FailCntWidth)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .ht_if(ht_if), .enable_i(enable_i),
        .window_i(window_i), .startup_wins_i(startup_wins_i), .alert_thresh_i(alert_thresh_i),
        .window_done_o(window_done_o), .window_fail_o(window_fail_o),
        .startup_done_o(startup_done_o), .watermark_o(watermark_o),
        .fail_total_o(fail_total_o), .alert_o(alert_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    int vectors = 0;
    int miscompares = 0;
    int done_count = 0;
    int fail_win_count = 0;
    int clear_count = 0;
    logic fail_carry = 1'b0;

    // Reference model: phase 0 idle, 1 startup, 2 continuous, 3 alert.
    int m_phase, m_fill, m_passes, m_consec, m_total, m_wm;
    bit m_entry, m_close_prev, m_fail_seen, m_alert, m_err;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // One call is one clock cycle; a failing sample's pulse appears on the next call.
    task automatic applyStimulus(input logic en, input logic vld, input logic fail_sample,
                                 input logic [RegWidth-1:0] cnt, input logic cerr);
        enable_i                = en;
        ht_if.entropy_bit_vld_i = vld;
        ht_if.test_fail_pulse_i = fail_carry;
        fail_carry              = en & vld & fail_sample;
        ht_if.test_cnt_i        = cnt;
        ht_if.count_err_i       = cerr;
        @(posedge clk_i);
        #1;
    endtask

    task automatic restart(input logic [WinWidth-1:0] win, input logic [3:0] wins,
                           input logic [FailCntWidth-1:0] thr);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
        window_i       = win;
        startup_wins_i = wins;
        alert_thresh_i = thr;
        applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b0);
    endtask

    task automatic runWindow4(input logic fail_last);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, 1'b1, fail_last, '0, 1'b0);
    endtask

    initial begin
        forever begin
            bit e_done, e_fail, n_entry;
            int n_phase, wsize;
            @(negedge clk_i);
            if (!rst_ni) begin
                m_phase = 0; m_fill = 0; m_passes = 0; m_consec = 0; m_total = 0; m_wm = 0;
                m_entry = 0; m_close_prev = 0; m_fail_seen = 0; m_alert = 0; m_err = 0;
            end
            e_done = m_close_prev && enable_i && rst_ni;
            e_fail = e_done && (m_fail_seen || ht_if.test_fail_pulse_i);
            checkOutput("ht_active", 32'(ht_if.ht_active_o), 32'(m_phase != 0));
            checkOutput("ht_clear", 32'(ht_if.ht_clear_o), 32'(m_entry));
            checkOutput("window_done", 32'(window_done_o), 32'(e_done));
            checkOutput("window_fail", 32'(window_fail_o), 32'(e_fail));
            checkOutput("startup_done", 32'(startup_done_o), 32'(m_phase >= 2));
            checkOutput("watermark", 32'(watermark_o), 32'(m_wm));
            checkOutput("fail_total", 32'(fail_total_o), 32'(m_total));
            checkOutput("alert", 32'(alert_o), 32'(m_alert));
            checkOutput("err", 32'(err_o), 32'(m_err));
            if (window_done_o === 1'b1) done_count++;
            if (window_fail_o === 1'b1) fail_win_count++;
            if (ht_if.ht_clear_o === 1'b1) clear_count++;
            if (rst_ni) begin
                n_phase = m_phase;
                n_entry = (m_phase == 0) && enable_i;
                if (m_entry) begin
                    m_fill = 0; m_fail_seen = 0; m_passes = 0; m_consec = 0;
                    m_total = 0; m_wm = 0; m_alert = 0; m_close_prev = 0;
                    if (startup_wins_i == 0) n_phase = 2;
                end else if (m_phase != 0) begin
                    wsize = (window_i == 0) ? 1 : int'(window_i);
                    if (e_done) begin
                        m_fail_seen = 0;
                        if (e_fail && m_phase <= 2) begin
                            if (m_consec < 15) m_consec++;
                            if (m_total < 65535) m_total++;
                            if (m_phase == 1) m_passes = 0;
                            if (alert_thresh_i != 0 && m_consec >= int'(alert_thresh_i)) n_phase = 3;
                        end else if (!e_fail && m_phase == 1) begin
                            m_passes++;
                            if (m_passes >= int'(startup_wins_i)) n_phase = 2;
                        end else if (!e_fail && m_phase == 2) begin
                            m_consec = 0;
                        end
                    end else if (enable_i && ht_if.test_fail_pulse_i) begin
                        m_fail_seen = 1;
                    end
                    m_close_prev = 0;
                    if (enable_i && ht_if.entropy_bit_vld_i) begin
                        m_fill++;
                        if (m_fill >= wsize) begin
                            m_fill = 0;
                            m_close_prev = 1;
                        end
                    end
                    if (int'(ht_if.test_cnt_i) > m_wm) m_wm = int'(ht_if.test_cnt_i);
                end else begin
                    m_close_prev = 0;
                    if (enable_i) n_phase = 1;
                end
                if (!enable_i) n_phase = 0;
                if (n_phase == 3) m_alert = 1;
                if (ht_if.count_err_i) m_err = 1;
                m_phase = n_phase;
                m_entry = n_entry;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int snap;
        rst_ni = 1'b0;
        enable_i = 1'b0; window_i = 16'd4; startup_wins_i = 4'd2; alert_thresh_i = 4'd3;
        ht_if.entropy_bit_vld_i = 1'b0; ht_if.test_fail_pulse_i = 1'b0;
        ht_if.test_cnt_i = '0; ht_if.count_err_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        checkOutput("rst_active", 32'(ht_if.ht_active_o), 32'd0);
        checkOutput("rst_err", 32'(err_o), 32'd0);
        rst_ni = 1'b1;

        $display("[TB] basic startup, window 4, two windows");
        restart(16'd4, 4'd2, 4'd3);
        checkOutput("s1_clear_low", 32'(ht_if.ht_clear_o), 32'd0);
        checkOutput("s1_active", 32'(ht_if.ht_active_o), 32'd1);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b0);
        checkOutput("s1_sdone_early", 32'(startup_done_o), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b0);
        checkOutput("s1_sdone", 32'(startup_done_o), 32'd1);
        checkOutput("s1_done_cnt", 32'(done_count), 32'd2);
        checkOutput("s1_clear_cnt", 32'(clear_count), 32'd1);

        $display("[TB] fail on last sample of first window");
        restart(16'd4, 4'd2, 4'd3);
        snap = fail_win_count;
        runWindow4(1'b1);
        runWindow4(1'b0);
        runWindow4(1'b0);
        checkOutput("s2_sdone_early", 32'(startup_done_o), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b0);
        checkOutput("s2_sdone", 32'(startup_done_o), 32'd1);
        checkOutput("s2_fail_total", 32'(fail_total_o), 32'd1);
        checkOutput("s2_fail_wins", 32'(fail_win_count - snap), 32'd1);

        $display("[TB] continuous mode, threshold 3");
        restart(16'd4, 4'd2, 4'd3);
        runWindow4(1'b0);
        runWindow4(1'b0);
        runWindow4(1'b1);
        runWindow4(1'b1);
        runWindow4(1'b0);
        runWindow4(1'b1);
        runWindow4(1'b1);
        runWindow4(1'b1);
        checkOutput("s3_no_alert", 32'(alert_o), 32'd0);
        runWindow4(1'b0);
        checkOutput("s3_alert", 32'(alert_o), 32'd1);
        runWindow4(1'b0);
        runWindow4(1'b0);
        checkOutput("s3_alert_sticky", 32'(alert_o), 32'd1);
        checkOutput("s3_fail_total", 32'(fail_total_o), 32'd5);
        snap = done_count;
        restart(16'd4, 4'd2, 4'd0);
        checkOutput("s3_close_discarded", 32'(done_count), 32'(snap));

        $display("[TB] alert disabled, 20 failing windows");
        runWindow4(1'b0);
        runWindow4(1'b0);
        for (int i = 0; i < 20; i++) runWindow4(1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
        checkOutput("s4_no_alert", 32'(alert_o), 32'd0);
        checkOutput("s4_fail_total", 32'(fail_total_o), 32'd20);

        $display("[TB] window 0 acts as 1, no startup windows, threshold 2");
        restart(16'd0, 4'd0, 4'd2);
        checkOutput("s5_sdone", 32'(startup_done_o), 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, '0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, '0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, '0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
        checkOutput("s5_alert", 32'(alert_o), 32'd1);
        checkOutput("s5_fail_total", 32'(fail_total_o), 32'd3);

        $display("[TB] watermark");
        restart(16'd4, 4'd2, 4'd3);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'd3, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'd9, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'd5, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'd0, 1'b0);
        checkOutput("s6_wm", 32'(watermark_o), 32'd9);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
        checkOutput("s6_wm_hold", 32'(watermark_o), 32'd9);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'd7, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'd7, 1'b0);
        checkOutput("s6_wm_cleared", 32'(watermark_o), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'd7, 1'b0);
        checkOutput("s6_wm_new", 32'(watermark_o), 32'd7);

        $display("[TB] count error and asynchronous reset");
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1);
        checkOutput("s7_err", 32'(err_o), 32'd1);
        restart(16'd4, 4'd2, 4'd3);
        checkOutput("s7_err_sticky", 32'(err_o), 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'd4, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'd4, 1'b0);
        #2;
        rst_ni = 1'b0;
        fail_carry = 1'b0;
        #1;
        checkOutput("s7_rst_err", 32'(err_o), 32'd0);
        checkOutput("s7_rst_active", 32'(ht_if.ht_active_o), 32'd0);
        checkOutput("s7_rst_wm", 32'(watermark_o), 32'd0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
        checkOutput("s7_idle_after_rst", 32'(ht_if.ht_active_o), 32'd0);

        @(negedge clk_i);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/entropy_src_repcnt_ctrl.md
# entropy_src_repcnt_ctrl

Controller that sequences the repetitive-count health test in entropy_src. It drives the test's active/clear controls and divides the sample stream into fixed-size windows. It runs a startup qualification phase followed by continuous monitoring, and raises a sticky alert after a programmable number of consecutive failing windows. It sits between the entropy_src main FSM/CSR block and the repcnt test instance, and also reports a high-watermark and a failure total.

## Interface
- RegWidth, 16, width of test count, watermark and failure total
- WinWidth, 16, width of window size counter
- FailCntWidth, 4, width of consecutive-fail counter and alert threshold
- clk_i  input  1  clock
- rst_ni  input  1  reset, asynchronous, active-low
- enable_i  input  1  health test enable from main FSM
- entropy_bit_vld_i  input  1  sample strobe, the same one fed to the test
- window_i  input  WinWidth  samples per window; 0 is treated as 1
- startup_wins_i  input  4  consecutive passing windows required in startup
- alert_thresh_i  input  FailCntWidth  consecutive failing windows that trigger alert; 0 disables alert
- test_fail_pulse_i  input  1  fail pulse from test, one cycle after the sample strobe
- test_cnt_i  input  RegWidth  current test count
- count_err_i  input  1  redundant-counter error from test
- ht_active_o  output  1  drives the test's active input
- ht_clear_o  output  1  drives the test's clear input
- window_done_o  output  1  one-cycle pulse at window close
- window_fail_o  output  1  window result, valid with window_done_o
- startup_done_o  output  1  high while in CONT or ALERT
- watermark_o  output  RegWidth  maximum test_cnt_i seen since start
- fail_total_o  output  RegWidth  saturating count of failing windows
- alert_o  output  1  sticky alert
- err_o  output  1  sticky fatal error

## Operation
- States: IDLE, STARTUP, CONT, ALERT. One-hot or sparse encoding; an illegal state sets err_o and forces ALERT.
- IDLE: ht_active_o=0. When enable_i=1, go to STARTUP.
- STARTUP entry cycle:
  - ht_clear_o=1 for exactly one cycle.
  - Clear the window counter, pass counter, consecutive-fail counter, fail flag, watermark and fail_total.
  - A sample strobe in this cycle is not counted.
- Windows:
  - The window counter increments on entropy_bit_vld_i while in STARTUP/CONT/ALERT (excluding the clear cycle).
  - The window closes at the strobe where the counter equals max(window_i,1)-1; the counter then wraps to 0.
  - fail_flag is set by any test_fail_pulse_i inside the window, including the pulse for the final sample, which arrives one cycle after that sample's strobe.
- STARTUP:
  - Passing window: pass count +1. When the pass count reaches startup_wins_i, go to CONT.
  - Failing window: pass count returns to 0.
  - startup_wins_i=0: go to CONT immediately after the clear cycle.
- CONT: a passing window clears the consecutive-fail counter.
- Any failing window (STARTUP or CONT):
  - Consecutive-fail counter +1, saturating.
  - fail_total +1, saturating at all-ones.
  - When the consecutive-fail counter reaches alert_thresh_i (nonzero), go to ALERT.
- ALERT: alert_o=1 and the test stays active. Windows and watermark keep updating. Exited only by enable_i=0.
- enable_i=0 in any state: go to IDLE next cycle.
  - alert_o, watermark_o and fail_total_o hold their values until the next STARTUP entry.
  - A window close in the same cycle is discarded: no window_done_o pulse.
- Watermark: each cycle in an active state, watermark = max(watermark, test_cnt_i).
- err_o: set by count_err_i or an illegal state; cleared only by reset.
- Config inputs must be stable while enable_i=1. A changed window_i takes effect at the next window start.

## Timing
- Reset values: all outputs 0, state IDLE.
- enable_i rising at cycle t:
  - STARTUP at t+1 with ht_active_o=1 and ht_clear_o=1.
  - ht_clear_o=0 from t+2; the first counted strobe can occur at t+2.
- Last strobe of a window at cycle c:
  - window_done_o and window_fail_o pulse at c+1; the result includes test_fail_pulse_i at c+1.
  - Counters and state update at c+2; alert_o and startup_done_o change at c+2.
- Strobes at c+1 belong to the next window. A fail pulse at c+1 is credited only to the closing window.
- ht_active_o is a registered state decode: it drops one cycle after enable_i falls.
- Reset mid-operation returns everything to reset values asynchronously.

## Test plan
- window_i=4, startup_wins_i=2, strobes every cycle, no fails:
  - window_done_o pulses every 4 strobes.
  - startup_done_o rises 2 cycles after the 2nd window close.
  - ht_clear_o is high for exactly 1 cycle.
- Same configuration, fail pulse on the last sample of window 1 (arriving one cycle after its strobe):
  - Window 1 reports window_fail_o=1.
  - Startup needs 2 further passing windows.
  - fail_total_o=1.
- CONT, alert_thresh_i=3:
  - fail, fail, pass, fail, fail leaves alert_o=0.
  - A 6th window failing raises alert_o=1.
  - alert_o stays 1 after a later passing window.
- alert_thresh_i=0 with 20 consecutive failing windows: alert_o stays 0 and fail_total_o=20.
- test_cnt_i sequence 3, 9, 5 while active: watermark_o=9. Toggling enable_i then clears it on STARTUP entry.
- count_err_i pulsed once: err_o=1 and sticky through enable_i toggling; cleared only by rst_ni.
